// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the two byte sources, the arbiter and the UART transmitter.
// The slave modport is the arbiter's view; master is the surrounding logic's view.
interface uart_tx_arbiter_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [7:0]    req0_data;
    logic          req0_valid;
    logic          req0_ready;
    logic [7:0]    req1_data;
    logic          req1_valid;
    logic          req1_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [1:0]    grant;
    logic [CW-1:0] count0;
    logic [CW-1:0] count1;

    modport slave (
        input  req0_data, req0_valid, req1_data, req1_valid, tx_ready,
        output req0_ready, req1_ready, tx_data, tx_valid, grant, count0, count1
    );

    modport master (
        output req0_data, req0_valid, req1_data, req1_valid, tx_ready,
        input  req0_ready, req1_ready, tx_data, tx_valid, grant, count0, count1
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Two per-requester byte FIFOs drained round-robin into the single UART transmitter.
// One byte at a time is held in a registered output stage until the UART accepts it.
module uart_tx_arbiter #(
    parameter int unsigned DEPTH = 4
) (
    input logic              clk,
    input logic              cpu_rst_n,
    uart_tx_arbiter_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic {StIdle, StPresent} state_e;

    state_e        state_q;
    logic [7:0]    tx_data_q;
    logic          tx_valid_q;
    logic [1:0]    grant_q;
    logic          last_grant_q;

    logic [7:0]    mem0_q [DEPTH];
    logic [7:0]    mem1_q [DEPTH];
    logic [PW-1:0] wr0_q, rd0_q, wr1_q, rd1_q;
    logic [CW-1:0] cnt0_q, cnt1_q;

    logic ready0, ready1, push0, push1;
    logic ne0, ne1, pick1, pop0, pop1;

    always_comb begin
        ready0 = cnt0_q < CW'(DEPTH);
        ready1 = cnt1_q < CW'(DEPTH);
        push0  = bus.req0_valid && ready0;
        push1  = bus.req1_valid && ready1;
        ne0    = cnt0_q != '0;
        ne1    = cnt1_q != '0;
        // Requester 1 wins when it is alone, or when both wait and 0 was served last.
        pick1  = ne1 && (!ne0 || !last_grant_q);
        pop0   = (state_q == StIdle) && ne0 && !pick1;
        pop1   = (state_q == StIdle) && pick1;
    end

    always_ff @(posedge clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            wr0_q  <= '0;
            rd0_q  <= '0;
            cnt0_q <= '0;
            wr1_q  <= '0;
            rd1_q  <= '0;
            cnt1_q <= '0;
        end else begin
            if (push0) wr0_q <= wr0_q + PW'(1);
            if (pop0)  rd0_q <= rd0_q + PW'(1);
            if (push1) wr1_q <= wr1_q + PW'(1);
            if (pop1)  rd1_q <= rd1_q + PW'(1);
            cnt0_q <= cnt0_q + CW'(push0) - CW'(pop0);
            cnt1_q <= cnt1_q + CW'(push1) - CW'(pop1);
        end
    end

    // Storage needs no reset: occupancy is governed by the reset counters and pointers.
    always_ff @(posedge clk) begin
        if (push0) mem0_q[wr0_q] <= bus.req0_data;
        if (push1) mem1_q[wr1_q] <= bus.req1_data;
    end

    always_ff @(posedge clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q      <= StIdle;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (pop0 || pop1) begin
                        tx_data_q  <= pop1 ? mem1_q[rd1_q] : mem0_q[rd0_q];
                        grant_q    <= pop1 ? 2'b10 : 2'b01;
                        tx_valid_q <= 1'b1;
                        state_q    <= StPresent;
                    end
                end
                StPresent: begin
                    if (bus.tx_ready) begin
                        last_grant_q <= grant_q[1];
                        tx_valid_q   <= 1'b0;
                        grant_q      <= 2'b00;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.tx_data    = tx_data_q;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.grant      = grant_q;
    assign bus.count0     = cnt0_q;
    assign bus.count1     = cnt1_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: cycle tables for the single-source and contention
// cases, plus sequences for full FIFO, backpressure, wrap-around and asynchronous reset.
module tb_uart_tx_arbiter;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic cpu_rst_n;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_arbiter #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .cpu_rst_n (cpu_rst_n),
        .bus       (bus)
    );

    typedef struct {
        logic       rst;
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       rdy;
        logic       ev;
        logic [7:0] ed;
        logic [1:0] eg;
        logic [2:0] ec0;
        logic [2:0] ec1;
    } vec_t;

    int errors = 0;
    int checks = 0;
    logic [7:0] got_q[$];
    logic [1:0] gnt_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Records a completed UART handshake from pre-edge values, then advances one cycle.
    task automatic tick();
        if (bus.tx_valid && bus.tx_ready) begin
            got_q.push_back(bus.tx_data);
            gnt_q.push_back(bus.grant);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req0_valid = 1'b0;
        bus.req0_data  = 8'h00;
        bus.req1_valid = 1'b0;
        bus.req1_data  = 8'h00;
        bus.tx_ready   = 1'b0;
        cpu_rst_n      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cpu_rst_n = 1'b1;
        got_q.delete();
        gnt_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    vec_t vecs[17];

    initial begin
        // Single requester, tx_ready high: 41,42,43 every other cycle.
        vecs[0]  = '{1'b1, 1'b1, 8'h41, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 2'b00, 3'd1, 3'd0};
        vecs[1]  = '{1'b0, 1'b1, 8'h42, 1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 2'b01, 3'd1, 3'd0};
        vecs[2]  = '{1'b0, 1'b1, 8'h43, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 2'b00, 3'd2, 3'd0};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h42, 2'b01, 3'd1, 3'd0};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 2'b00, 3'd1, 3'd0};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h43, 2'b01, 3'd0, 3'd0};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 2'b00, 3'd0, 3'd0};
        // Contention: fill both with tx_ready low, then drain 10,20,11,21.
        vecs[7]  = '{1'b1, 1'b1, 8'h10, 1'b1, 8'h20, 1'b0, 1'b0, 8'h00, 2'b00, 3'd1, 3'd1};
        vecs[8]  = '{1'b0, 1'b1, 8'h11, 1'b1, 8'h21, 1'b0, 1'b1, 8'h10, 2'b01, 3'd1, 3'd2};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h10, 2'b01, 3'd1, 3'd2};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 2'b00, 3'd1, 3'd2};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 2'b10, 3'd1, 3'd1};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 2'b00, 3'd1, 3'd1};
        vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 2'b01, 3'd0, 3'd1};
        vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 2'b00, 3'd0, 3'd1};
        vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h21, 2'b10, 3'd0, 3'd0};
        vecs[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 2'b00, 3'd0, 3'd0};

        // Reset state after 3 cycles low.
        do_reset();
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_count0", 32'(bus.count0), 32'd0);
        chk("rst_count1", 32'(bus.count1), 32'd0);
        chk("rst_ready0", 32'(bus.req0_ready), 32'd1);
        chk("rst_ready1", 32'(bus.req1_ready), 32'd1);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            bus.req0_valid = vecs[i].v0;
            bus.req0_data  = vecs[i].d0;
            bus.req1_valid = vecs[i].v1;
            bus.req1_data  = vecs[i].d1;
            bus.tx_ready   = vecs[i].rdy;
            tick();
            chk($sformatf("vec%0d_tx_valid", i), 32'(bus.tx_valid), 32'(vecs[i].ev));
            chk($sformatf("vec%0d_grant", i), 32'(bus.grant), 32'(vecs[i].eg));
            chk($sformatf("vec%0d_count0", i), 32'(bus.count0), 32'(vecs[i].ec0));
            chk($sformatf("vec%0d_count1", i), 32'(bus.count1), 32'(vecs[i].ec1));
            chk($sformatf("vec%0d_ready0", i), 32'(bus.req0_ready), 32'(vecs[i].ec0 < 3'd4));
            chk($sformatf("vec%0d_ready1", i), 32'(bus.req1_ready), 32'(vecs[i].ec1 < 3'd4));
            if (vecs[i].ev) chk($sformatf("vec%0d_tx_data", i), 32'(bus.tx_data),
                                32'(vecs[i].ed));
        end

        // Full FIFO: the output register takes B0, then B1..B4 fill FIFO1; B5 must wait.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.req1_data  = 8'(8'hB0 + i);
            bus.req1_valid = 1'b1;
            chk($sformatf("full_ready_push%0d", i), 32'(bus.req1_ready), 32'd1);
            tick();
        end
        bus.req1_data = 8'hB5;
        chk("full_count1", 32'(bus.count1), 32'd4);
        chk("full_ready1_low", 32'(bus.req1_ready), 32'd0);
        chk("full_tx_data", 32'(bus.tx_data), 32'hB0);
        chk("full_grant", 32'(bus.grant), 32'b10);
        tick();
        tick();
        chk("full_held_count1", 32'(bus.count1), 32'd4);
        chk("full_held_ready1", 32'(bus.req1_ready), 32'd0);
        bus.tx_ready = 1'b1;
        begin
            logic acc;
            acc = 1'b0;
            for (int n = 0; n < 20 && !acc; n++) begin
                acc = bus.req1_valid && bus.req1_ready;
                tick();
            end
            bus.req1_valid = 1'b0;
            chk("full_held_byte_accepted", 32'(acc), 32'd1);
            chk("full_count1_back_to_4", 32'(bus.count1), 32'd4);
        end
        for (int n = 0; n < 40 && got_q.size() < 6; n++) tick();
        chk("full_drain_count", 32'(got_q.size()), 32'd6);
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            chk($sformatf("full_drain_byte%0d", i), 32'(got_q[i]), 32'(8'(8'hB0 + i)));
            chk($sformatf("full_drain_grant%0d", i), 32'(gnt_q[i]), 32'b10);
        end

        // Backpressure: 0x55 held for 7 cycles, then exactly one completion.
        do_reset();
        bus.req0_data  = 8'h55;
        bus.req0_valid = 1'b1;
        tick();
        bus.req0_valid = 1'b0;
        tick();
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("bp_valid_c%0d", k), 32'(bus.tx_valid), 32'd1);
            chk($sformatf("bp_data_c%0d", k), 32'(bus.tx_data), 32'h55);
            tick();
        end
        bus.tx_ready = 1'b1;
        repeat (4) tick();
        chk("bp_completions", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) chk("bp_byte", 32'(got_q[0]), 32'h55);
        chk("bp_idle_after", 32'(bus.tx_valid), 32'd0);

        // Wrap-around: 10 bytes through a 4-deep FIFO under random tx_ready.
        do_reset();
        begin
            int  next;
            logic acc;
            next = 0;
            for (int cyc = 0; cyc < 400 && (next < 10 || got_q.size() < 10); cyc++) begin
                bus.tx_ready = 1'($urandom_range(0, 1));
                bus.req0_valid = (next < 10);
                bus.req0_data  = 8'(next);
                acc = bus.req0_valid && bus.req0_ready;
                tick();
                if (acc) next++;
            end
            bus.req0_valid = 1'b0;
            bus.tx_ready   = 1'b0;
        end
        chk("wrap_count", 32'(got_q.size()), 32'd10);
        for (int i = 0; i < 10 && i < got_q.size(); i++) begin
            chk($sformatf("wrap_byte%0d", i), 32'(got_q[i]), 32'(i));
            chk($sformatf("wrap_grant%0d", i), 32'(gnt_q[i]), 32'b01);
        end

        // Asynchronous reset while presenting with tx_ready low.
        do_reset();
        bus.req0_data  = 8'h66;
        bus.req0_valid = 1'b1;
        tick();
        bus.req0_data = 8'h67;
        tick();
        bus.req0_valid = 1'b0;
        chk("arst_pre_valid", 32'(bus.tx_valid), 32'd1);
        chk("arst_pre_count0", 32'(bus.count0), 32'd1);
        #2;
        cpu_rst_n = 1'b0;
        #1;
        chk("arst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("arst_grant", 32'(bus.grant), 32'd0);
        chk("arst_count0", 32'(bus.count0), 32'd0);
        chk("arst_ready0", 32'(bus.req0_ready), 32'd1);
        @(posedge clk);
        #1;
        cpu_rst_n = 1'b1;
        tick();
        chk("arst_stays_idle", 32'(bus.tx_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
